// File: rtl/bp_be_instr_decode_buffer.sv
// RV64 base-format decoder feeding a 2-entry in-order queue.
// Fetch sees registered backpressure; the issue stage pops the head.
module bp_be_instr_decode_buffer #(
    parameter int vaddr_width_p     = 39,
    parameter bit illegal_on_zero_p = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     flush_i,
    input  logic                     instr_v_i,
    output logic                     instr_ready_o,
    input  logic [vaddr_width_p-1:0] pc_i,
    input  logic [31:0]              instr_i,
    output logic                     decoded_v_o,
    input  logic                     decoded_ready_i,
    output logic [vaddr_width_p-1:0] pc_o,
    output logic [31:0]              instr_o,
    output logic [3:0]               opclass_o,
    output logic [4:0]               rd_addr_o,
    output logic [4:0]               rs1_addr_o,
    output logic [4:0]               rs2_addr_o,
    output logic [2:0]               funct3_o,
    output logic [6:0]               funct7_o,
    output logic [63:0]              imm_o,
    output logic                     rd_w_v_o,
    output logic                     illegal_o
);

    typedef struct packed {
        logic [vaddr_width_p-1:0] pc;
        logic [31:0]              instr;
        logic [3:0]               opclass;
        logic [63:0]              imm;
        logic                     rd_w_v;
        logic                     illegal;
    } entry_t;

    entry_t      dec;
    entry_t      mem_q [2];
    entry_t      head;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        enq, deq, writes_rd, bad;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{52{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
    assign imm_j = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        dec       = '0;
        dec.pc    = pc_i;
        dec.instr = instr_i;
        writes_rd = 1'b0;
        bad       = 1'b0;
        case (instr_i[6:0])
            7'h37: begin dec.opclass = 4'd0;  dec.imm = imm_u; writes_rd = 1'b1; end
            7'h17: begin dec.opclass = 4'd1;  dec.imm = imm_u; writes_rd = 1'b1; end
            7'h6f: begin dec.opclass = 4'd2;  dec.imm = imm_j; writes_rd = 1'b1; end
            7'h67: begin dec.opclass = 4'd3;  dec.imm = imm_i; writes_rd = 1'b1; end
            7'h63: begin dec.opclass = 4'd4;  dec.imm = imm_b; end
            7'h03: begin dec.opclass = 4'd5;  dec.imm = imm_i; writes_rd = 1'b1; end
            7'h23: begin dec.opclass = 4'd6;  dec.imm = imm_s; end
            7'h13: begin dec.opclass = 4'd7;  dec.imm = imm_i; writes_rd = 1'b1; end
            7'h1b: begin dec.opclass = 4'd8;  dec.imm = imm_i; writes_rd = 1'b1; end
            7'h33: begin dec.opclass = 4'd9;  writes_rd = 1'b1; end
            7'h3b: begin dec.opclass = 4'd10; writes_rd = 1'b1; end
            7'h0f: begin dec.opclass = 4'd11; dec.imm = imm_i; end
            7'h73: begin dec.opclass = 4'd12; dec.imm = imm_i; writes_rd = 1'b1; end
            7'h2f: begin dec.opclass = 4'd13; writes_rd = 1'b1; end
            default: bad = 1'b1;
        endcase
        // Every table opcode ends in 2'b11; the explicit check keeps compressed space illegal.
        if (instr_i[1:0] != 2'b11 || (illegal_on_zero_p && instr_i == 32'h0))
            bad = 1'b1;
        dec.rd_w_v  = writes_rd & (instr_i[11:7] != 5'd0) & ~bad;
        dec.illegal = bad;
        if (bad) begin
            dec.opclass = 4'd15;
            dec.imm     = '0;
        end
    end

    assign instr_ready_o = (count_q != 2'd2);
    assign decoded_v_o   = (count_q != 2'd0);
    assign enq           = instr_v_i & instr_ready_o & ~flush_i;
    assign deq           = decoded_v_o & decoded_ready_i & ~flush_i;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (enq) wr_ptr_d = ~wr_ptr_q;
            if (deq) rd_ptr_d = ~rd_ptr_q;
            case ({enq, deq})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (enq) mem_q[wr_ptr_q] <= dec;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign pc_o       = head.pc;
    assign instr_o    = head.instr;
    assign opclass_o  = head.opclass;
    assign rd_addr_o  = head.instr[11:7];
    assign rs1_addr_o = head.instr[19:15];
    assign rs2_addr_o = head.instr[24:20];
    assign funct3_o   = head.instr[14:12];
    assign funct7_o   = head.instr[31:25];
    assign imm_o      = head.imm;
    assign rd_w_v_o   = head.rd_w_v;
    assign illegal_o  = head.illegal;

endmodule
